// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_if
//  Brief    : Decode-stage bus to the register file: two read ports,
//             one writeback port, issue request and stall.
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_file_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          re1;
    logic [AW-1:0] raddr1;
    logic [DW-1:0] op1_rdata;
    logic          re2;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] op2_rdata;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          stall;

    modport master (
        output re1, raddr1, re2, raddr2,
        output we, waddr, wdata,
        output issue_valid, issue_rd,
        input  op1_rdata, op2_rdata, stall
    );

    modport slave (
        input  re1, raddr1, re2, raddr2,
        input  we, waddr, wdata,
        input  issue_valid, issue_rd,
        output op1_rdata, op2_rdata, stall
    );
endinterface
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file
//  Brief    : General-purpose register file with write-through bypass and a
//             per-register busy scoreboard raising stall on RAW/WAW hazards.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    reg_file_if.slave   bus
);

    logic [DW-1:0]    r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_next;

    logic w_wr_valid;
    logic w_clr1;
    logic w_clr2;
    logic w_clr_rd;
    logic w_raw1;
    logic w_raw2;
    logic w_waw;
    logic w_stall;

    assign w_wr_valid = bus.we && (bus.waddr != '0);

    // A writeback landing this cycle resolves the hazard it would otherwise raise.
    assign w_clr1   = bus.we && (bus.waddr == bus.raddr1);
    assign w_clr2   = bus.we && (bus.waddr == bus.raddr2);
    assign w_clr_rd = bus.we && (bus.waddr == bus.issue_rd);

    assign w_raw1 = bus.re1 && (bus.raddr1 != '0) && r_busy[bus.raddr1] && !w_clr1;
    assign w_raw2 = bus.re2 && (bus.raddr2 != '0) && r_busy[bus.raddr2] && !w_clr2;
    assign w_waw  = bus.issue_valid && (bus.issue_rd != '0) && r_busy[bus.issue_rd] && !w_clr_rd;

    assign w_stall   = w_raw1 | w_raw2 | w_waw;
    assign bus.stall = w_stall;

    always_comb begin
        bus.op1_rdata = '0;
        if (bus.re1 && (bus.raddr1 != '0)) begin
            if (w_wr_valid && (bus.waddr == bus.raddr1)) begin
                bus.op1_rdata = bus.wdata;
            end else begin
                bus.op1_rdata = r_regs[bus.raddr1];
            end
        end
    end

    always_comb begin
        bus.op2_rdata = '0;
        if (bus.re2 && (bus.raddr2 != '0)) begin
            if (w_wr_valid && (bus.waddr == bus.raddr2)) begin
                bus.op2_rdata = bus.wdata;
            end else begin
                bus.op2_rdata = r_regs[bus.raddr2];
            end
        end
    end

    // Set beats clear: the newly issued producer is still in flight.
    always_comb begin
        w_busy_next = r_busy;
        for (int i = 1; i < NREGS; i++) begin
            if (bus.issue_valid && !w_stall && (bus.issue_rd == AW'(i))) begin
                w_busy_next[i] = 1'b1;
            end else if (bus.we && (bus.waddr == AW'(i))) begin
                w_busy_next[i] = 1'b0;
            end
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[bus.waddr] <= bus.wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file
//  Brief    : Directed self-checking bench for reg_file.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    localparam int c_NREGS = 32;
    localparam int c_AW    = 5;
    localparam int c_DW    = 32;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    reg_file_if #(.AW(c_AW), .DW(c_DW)) bus ();

    reg_file #(
        .NREGS (c_NREGS),
        .AW    (c_AW),
        .DW    (c_DW)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change here, checks follow #2 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.re1 = 1'b0; bus.raddr1 = '0;
        bus.re2 = 1'b0; bus.raddr2 = '0;
        bus.we = 1'b0;  bus.waddr = '0; bus.wdata = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();

        // Reset sequence
        tick();
        tick();
        rst_n = 1'b1;
        bus.re1 = 1'b1; bus.raddr1 = 5'd7;
        #2;
        chk("rst_op1", bus.op1_rdata, 32'h0);
        chk("rst_stall", {31'b0, bus.stall}, 32'h0);
        chk("rst_op2_dis", bus.op2_rdata, 32'h0);

        // Basic write then read
        tick();
        idle();
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF;
        tick();
        idle();
        bus.re2 = 1'b1; bus.raddr2 = 5'd5;
        #2;
        chk("wr_rd_r5", bus.op2_rdata, 32'hDEADBEEF);
        bus.re2 = 1'b0;
        #1;
        chk("re2_off", bus.op2_rdata, 32'h0);

        // Same-cycle bypass, then array read from both ports
        tick();
        idle();
        bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h1234;
        bus.re1 = 1'b1; bus.raddr1 = 5'd3;
        #2;
        chk("bypass_r3", bus.op1_rdata, 32'h1234);
        tick();
        bus.we = 1'b0; bus.wdata = 32'h0;
        bus.re2 = 1'b1; bus.raddr2 = 5'd3;
        #2;
        chk("array_r3_p1", bus.op1_rdata, 32'h1234);
        chk("array_r3_p2", bus.op2_rdata, 32'h1234);

        // Register zero: writes dropped, never busy
        tick();
        idle();
        bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
        bus.re1 = 1'b1; bus.raddr1 = 5'd0;
        #2;
        chk("r0_nobypass", bus.op1_rdata, 32'h0);
        tick();
        bus.we = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        #2;
        chk("r0_read", bus.op1_rdata, 32'h0);
        chk("r0_issue_stall", {31'b0, bus.stall}, 32'h0);
        tick();
        #2;
        chk("r0_reissue_stall", {31'b0, bus.stall}, 32'h0);

        // RAW on r9 until writeback
        tick();
        idle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        #2;
        chk("issue_r9_stall", {31'b0, bus.stall}, 32'h0);
        tick();
        idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd9;
        #2;
        chk("raw_r9_c1", {31'b0, bus.stall}, 32'h1);
        tick();
        #2;
        chk("raw_r9_c2", {31'b0, bus.stall}, 32'h1);
        bus.re1 = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        #1;
        chk("waw_r9", {31'b0, bus.stall}, 32'h1);
        tick();
        idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd9;
        bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'hCAFE0009;
        #2;
        chk("wb_r9_stall", {31'b0, bus.stall}, 32'h0);
        chk("wb_r9_data", bus.op1_rdata, 32'hCAFE0009);
        tick();
        bus.we = 1'b0; bus.wdata = 32'h0;
        #2;
        chk("post_wb_stall", {31'b0, bus.stall}, 32'h0);
        chk("post_wb_data", bus.op1_rdata, 32'hCAFE0009);

        // RAW seen on port 2
        tick();
        idle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd10;
        tick();
        idle();
        bus.re2 = 1'b1; bus.raddr2 = 5'd10;
        #2;
        chk("raw_p2_r10", {31'b0, bus.stall}, 32'h1);

        // Set wins over simultaneous clear, then reset wipes state
        tick();
        idle();
        bus.we = 1'b1; bus.waddr = 5'd10; bus.wdata = 32'hA;
        tick();
        idle();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
        bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h44;
        #2;
        chk("soc_stall", {31'b0, bus.stall}, 32'h0);
        tick();
        idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd4;
        bus.re2 = 1'b1; bus.raddr2 = 5'd10;
        #2;
        chk("soc_busy_r4", {31'b0, bus.stall}, 32'h1);
        chk("soc_data_r4", bus.op1_rdata, 32'h44);
        chk("r10_cleared", bus.op2_rdata, 32'hA);
        bus.re1 = 1'b0;
        #1;
        chk("r10_not_busy", {31'b0, bus.stall}, 32'h0);
        tick();
        idle();
        rst_n = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd6;
        bus.we = 1'b1; bus.waddr = 5'd6; bus.wdata = 32'h66;
        tick();
        rst_n = 1'b1;
        idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd4;
        #2;
        chk("rst_r4_stall", {31'b0, bus.stall}, 32'h0);
        chk("rst_r4_data", bus.op1_rdata, 32'h0);
        bus.re1 = 1'b0;
        bus.re2 = 1'b1; bus.raddr2 = 5'd6;
        #1;
        chk("rst_r6_data", bus.op2_rdata, 32'h0);
        chk("rst_r6_stall", {31'b0, bus.stall}, 32'h0);
        bus.re2 = 1'b1; bus.raddr2 = 5'd5;
        #1;
        chk("rst_r5_data", bus.op2_rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
